// File: rtl/safe_lock_pkg.sv
// Shared types and constants for the safe lock controller and its dwell timer.
package safe_lock_pkg;

  localparam int unsigned CODE_W  = 16;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [CODE_W-1:0] CODE_DEFAULT = 16'h1234;

  typedef enum logic [2:0] {
    LOCKED      = 3'd0,
    CHECK       = 3'd1,
    UNLOCKED    = 3'd2,
    LOCKOUT     = 3'd3,
    PROGRAM     = 3'd4,
    CHECK_CLEAR = 3'd5
  } state_t;

  // Timer must hold N-1 for the longer of the two dwell periods.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    return (a > b) ? $clog2(a) : $clog2(b);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter with a registered zero flag, shared by all timed states.
module dwell_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      zero  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      zero  <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/safe_lock_fsm.sv
// Safe lock control FSM: code check, unlock dwell, failure counting and alarm lockout.
// Optional code programming from the unlocked state via SAFE_LOCK_PROGRAM_MODE_EN.
module safe_lock_fsm
  import safe_lock_pkg::*;
#(
  parameter logic [CODE_W-1:0] DEFAULT_CODE   = CODE_DEFAULT,
  parameter int unsigned       MAX_ATTEMPTS   = 3,
  parameter int unsigned       UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned       LOCKOUT_CYCLES = 250_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] entered_code,
  input  logic              done,
  input  logic              lock_btn,
  input  logic              prog_btn,
  output logic              clear_entry,
  output logic              unlocked,
  output logic              alarm,
  output logic [3:0]        attempts_left
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMER_W = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

  localparam logic [CNT_W-1:0]   MAX_CNT      = CNT_W'(MAX_ATTEMPTS);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [CODE_W-1:0]  stored_code_q;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               clear_entry_d, unlocked_d, alarm_d;
  logic [3:0]         attempts_left_d;

`ifdef SAFE_LOCK_PROGRAM_MODE_EN
  logic [CODE_W-1:0] stored_code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored_code_q <= DEFAULT_CODE;
    end else begin
      stored_code_q <= stored_code_d;
    end
  end
`else
  logic unused_prog_btn;

  assign stored_code_q   = DEFAULT_CODE;
  assign unused_prog_btn = prog_btn;
`endif

  dwell_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next state plus next-cycle Moore output decode.
  always_comb begin
    state_d      = state_q;
    fail_d       = fail_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
`ifdef SAFE_LOCK_PROGRAM_MODE_EN
    stored_code_d = stored_code_q;
`endif
    case (state_q)
      LOCKED: begin
        if (done) state_d = CHECK;
      end
      CHECK: begin
        if (entered_code == stored_code_q) begin
          state_d      = UNLOCKED;
          fail_d       = '0;
          tmr_load     = 1'b1;
          tmr_load_val = UNLOCK_LOAD;
        end else if (CNT_W'(fail_q + CNT_W'(1)) == MAX_CNT) begin
          state_d      = LOCKOUT;
          fail_d       = MAX_CNT;
          tmr_load     = 1'b1;
          tmr_load_val = LOCKOUT_LOAD;
        end else begin
          state_d = LOCKED;
          fail_d  = CNT_W'(fail_q + CNT_W'(1));
        end
      end
      UNLOCKED: begin
        if (lock_btn || tmr_zero) begin
          state_d = LOCKED;
`ifdef SAFE_LOCK_PROGRAM_MODE_EN
        end else if (prog_btn) begin
          state_d = PROGRAM;
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_d = LOCKED;
          fail_d  = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
`ifdef SAFE_LOCK_PROGRAM_MODE_EN
      PROGRAM: begin
        if (lock_btn) begin
          state_d = LOCKED;
        end else if (done) begin
          stored_code_d = entered_code;
          state_d       = CHECK_CLEAR;
        end
      end
      CHECK_CLEAR: begin
        state_d = LOCKED;
      end
`endif
      default: begin
        state_d = LOCKED;
      end
    endcase

    clear_entry_d   = (state_d == CHECK) || (state_d == UNLOCKED) ||
                      (state_d == LOCKOUT) || (state_d == CHECK_CLEAR);
    unlocked_d      = (state_d == UNLOCKED) || (state_d == PROGRAM);
    alarm_d         = (state_d == LOCKOUT);
    attempts_left_d = MAX_CNT - fail_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOCKED;
      fail_q        <= '0;
      clear_entry   <= 1'b0;
      unlocked      <= 1'b0;
      alarm         <= 1'b0;
      attempts_left <= MAX_CNT;
    end else begin
      state_q       <= state_d;
      fail_q        <= fail_d;
      clear_entry   <= clear_entry_d;
      unlocked      <= unlocked_d;
      alarm         <= alarm_d;
      attempts_left <= attempts_left_d;
    end
  end

endmodule

// File: tb/tb_safe_lock_fsm.sv
// Self-checking bench for safe_lock_fsm against a dwell-count reference model.
// Exercises the programming path when SAFE_LOCK_PROGRAM_MODE_EN is defined.
module tb_safe_lock_fsm;

  localparam int unsigned UNLOCK_N  = 8;
  localparam int unsigned LOCKOUT_N = 16;
  localparam int unsigned MAX_N     = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] entered_code;
  logic        done;
  logic        lock_btn;
  logic        prog_btn;
  logic        clear_entry;
  logic        unlocked;
  logic        alarm;
  logic [3:0]  attempts_left;

  int vectors;
  int errors;

  // Reference model: remaining dwell cycles and pending one-cycle phases.
  bit          m_check;
  bit          m_prog;
  bit          m_clr;
  int          m_open;
  int          m_alarm;
  int          m_fails;
  logic [15:0] m_code;

  safe_lock_fsm #(
    .DEFAULT_CODE   (16'h1234),
    .MAX_ATTEMPTS   (MAX_N),
    .UNLOCK_CYCLES  (UNLOCK_N),
    .LOCKOUT_CYCLES (LOCKOUT_N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entered_code  (entered_code),
    .done          (done),
    .lock_btn      (lock_btn),
    .prog_btn      (prog_btn),
    .clear_entry   (clear_entry),
    .unlocked      (unlocked),
    .alarm         (alarm),
    .attempts_left (attempts_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_check = 1'b0;
    m_prog  = 1'b0;
    m_clr   = 1'b0;
    m_open  = 0;
    m_alarm = 0;
    m_fails = 0;
    m_code  = 16'h1234;
  endtask

  task automatic model_step(input logic d, input logic l, input logic p, input logic [15:0] c);
    if (m_check) begin
      m_check = 1'b0;
      if (c == m_code) begin
        m_fails = 0;
        m_open  = UNLOCK_N;
      end else if (m_fails + 1 == MAX_N) begin
        m_fails = MAX_N;
        m_alarm = LOCKOUT_N;
      end else begin
        m_fails++;
      end
    end else if (m_open > 0) begin
      if (l || m_open == 1) begin
        m_open = 0;
`ifdef SAFE_LOCK_PROGRAM_MODE_EN
      end else if (p) begin
        m_open = 0;
        m_prog = 1'b1;
`endif
      end else begin
        m_open--;
      end
    end else if (m_prog) begin
      if (l) begin
        m_prog = 1'b0;
      end else if (d) begin
        m_code = c;
        m_prog = 1'b0;
        m_clr  = 1'b1;
      end
    end else if (m_clr) begin
      m_clr = 1'b0;
    end else if (m_alarm > 0) begin
      m_alarm--;
      if (m_alarm == 0) m_fails = 0;
    end else if (d) begin
      m_check = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("clear_entry", 16'(clear_entry), 16'(m_check || m_open > 0 || m_alarm > 0 || m_clr));
    chk("unlocked", 16'(unlocked), 16'(m_open > 0 || m_prog));
    chk("alarm", 16'(alarm), 16'(m_alarm > 0));
    chk("attempts_left", 16'(attempts_left), 16'(MAX_N - m_fails));
  endtask

  task automatic cycle(input logic d, input logic l, input logic p, input logic [15:0] c);
    done         = d;
    lock_btn     = l;
    prog_btn     = p;
    entered_code = c;
    @(posedge clk);
    model_step(d, l, p, c);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic enter(input logic [15:0] c);
    cycle(1'b1, 1'b0, 1'b0, c);
    cycle(1'b0, 1'b0, 1'b0, c);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_clear_entry", 16'(clear_entry), 16'h0);
    chk("rst_unlocked", 16'(unlocked), 16'h0);
    chk("rst_alarm", 16'(alarm), 16'h0);
    chk("rst_attempts_left", 16'(attempts_left), 16'h3);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    rst_n        = 1'b0;
    done         = 1'b0;
    lock_btn     = 1'b0;
    prog_btn     = 1'b0;
    entered_code = 16'h0000;
    model_reset();
    @(posedge clk);
    #1;
    pulse_reset();

    // Correct code: CHECK for one cycle, then open for exactly UNLOCK_N cycles.
    enter(16'h1234);
    chk("open_after_2_edges", 16'(unlocked), 16'h1);
    idle(UNLOCK_N + 2);

    // Two wrong codes then the right one.
    enter(16'h0000);
    chk("attempts_after_1", 16'(attempts_left), 16'h2);
    enter(16'h9999);
    chk("attempts_after_2", 16'(attempts_left), 16'h1);
    enter(16'h1234);
    chk("attempts_restored", 16'(attempts_left), 16'h3);
    idle(UNLOCK_N);

    // Three failures: lockout with ignored done pulses.
    enter(16'h0000);
    enter(16'h1111);
    enter(16'h9999);
    chk("lockout_attempts", 16'(attempts_left), 16'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 16'h1234);
      cycle(1'b0, 1'b0, 1'b0, 16'h1234);
    end
    idle(LOCKOUT_N - 12 + 2);
    chk("post_lockout_alarm", 16'(alarm), 16'h0);

    // lock_btn on cycle 3 of the open period.
    enter(16'h1234);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("lock_btn_relock", 16'(unlocked), 16'h0);
    idle(2);

    // lock_btn coinciding with timer expiry.
    enter(16'h1234);
    idle(UNLOCK_N - 1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("lock_at_expiry", 16'(unlocked), 16'h0);
    idle(2);

    // Reset in the middle of a lockout.
    enter(16'h0001);
    enter(16'h0002);
    enter(16'h0003);
    idle(4);
    chk("lockout_mid_alarm", 16'(alarm), 16'h1);
    pulse_reset();
    enter(16'h1234);
    chk("unlock_after_reset", 16'(unlocked), 16'h1);
    idle(UNLOCK_N);

`ifdef SAFE_LOCK_PROGRAM_MODE_EN
    // Reprogram to 5678, verify old and new codes, then reset restores default.
    enter(16'h1234);
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 16'h5678);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("prog_relocked", 16'(unlocked), 16'h0);
    enter(16'h1234);
    chk("old_code_fails", 16'(attempts_left), 16'h2);
    enter(16'h5678);
    chk("new_code_opens", 16'(unlocked), 16'h1);
    idle(UNLOCK_N);
    pulse_reset();
    enter(16'h1234);
    chk("default_restored", 16'(unlocked), 16'h1);
    idle(UNLOCK_N);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] c;
      case ($urandom_range(0, 3))
        0:       c = 16'h1234;
        1:       c = 16'h0000;
        2:       c = 16'h9999;
        default: c = 16'($urandom);
      endcase
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 7) == 0), c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
